fetch_stage: RTL

//  Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
//  - Owns the PC and drives the synchronous instruction memory address.
//  - Captures the returned word into the IF/ID register; Opcode feeds the decode Controller.
//  - Honours stall from hazard detection and redirect/flush from the branch unit.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, major opcodes, fetch FSM states
// and the IF/ID pipeline record.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0, x0, 0

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    RESET,
    FILL,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Update priority: reset, squash (redirect/flush),
// stall (hold), then load of the fetched word.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        INS_W    = 32,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_squash,
  input  logic             i_stall,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [INS_W-1:0] i_instr,
  input  logic             i_valid,
  output logic [PC_W-1:0]  o_pc,
  output logic [INS_W-1:0] o_instr,
  output logic             o_valid
);

  // Squash keeps the PC field; only the instruction and valid bit are replaced.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_pc    <= RESET_PC;
      o_instr <= INS_W'(NOP_INSTR);
      o_valid <= 1'b0;
    end else if (i_squash) begin
      o_instr <= INS_W'(NOP_INSTR);
      o_valid <= 1'b0;
    end else if (!i_stall) begin
      o_pc    <= i_pc;
      o_instr <= i_instr;
      o_valid <= i_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous imem addressing,
// fetch FSM and IF/ID register. Optional performance counters are built
// only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [PC_W-1:0]  RedirectPC,
  input  logic             Flush,
  output logic [PC_W-1:0]  ImemAddr,
  input  logic [INS_W-1:0] ImemRdata,
  output logic [PC_W-1:0]  IfIdPC,
  output logic [INS_W-1:0] IfIdInstr,
  output logic             IfIdValid,
  output logic [6:0]       Opcode,
  output logic [31:0]      FetchCnt,
  output logic [31:0]      BubbleCnt
);

  fetch_state_e    r_state;
  logic            r_fetch_valid;
  logic [PC_W-1:0] r_pcf;
  logic            w_rst_eff;
  logic            w_squash;
  logic            w_unused_redirect_lsbs;

  // The word read during the last reset edge is never delivered: the first
  // post-reset cycle re-issues RESET_PC and keeps IF/ID cleared, so FILL
  // sees a fresh RESET_PC word and IF/ID shows a bubble in FILL.
  assign w_rst_eff = reset || (r_state == RESET);
  assign w_squash  = Redirect || Flush;
  assign w_unused_redirect_lsbs = ^RedirectPC[1:0];

  // Next fetch address: reset, redirect (word aligned), stall hold, sequential.
  always_comb begin
    ImemAddr = r_pcf + PC_W'(4);
    if (w_rst_eff)     ImemAddr = RESET_PC;
    else if (Redirect) ImemAddr = {RedirectPC[PC_W-1:2], 2'b00};
    else if (Stall)    ImemAddr = r_pcf;
  end

  // PcF tracks the address whose word is on ImemRdata this cycle.
  always_ff @(posedge clk) begin
    r_pcf <= ImemAddr;
  end

  // Fetch control FSM: RESET -> FILL -> RUN; FetchValid registered with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RESET;
      r_fetch_valid <= 1'b0;
    end else begin
      case (r_state)
        RESET:   r_state <= FILL;
        FILL:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
      r_fetch_valid <= 1'b1;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INS_W   (INS_W),
    .RESET_PC(RESET_PC)
  ) u_if_id (
    .clk     (clk),
    .i_reset (w_rst_eff),
    .i_squash(w_squash),
    .i_stall (Stall),
    .i_pc    (r_pcf),
    .i_instr (ImemRdata),
    .i_valid (r_fetch_valid),
    .o_pc    (IfIdPC),
    .o_instr (IfIdInstr),
    .o_valid (IfIdValid)
  );

  assign Opcode = IfIdInstr[6:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Saturating counts of IF/ID loads; held and reset-cleared cycles not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!w_rst_eff) begin
      if (w_squash || (!Stall && !r_fetch_valid)) begin
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end else if (!Stall) begin
        if (r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign FetchCnt  = r_fetch_cnt;
  assign BubbleCnt = r_bubble_cnt;
`else
  assign FetchCnt  = '0;
  assign BubbleCnt = '0;
`endif

endmodule
